// File: rtl/conv_addr_gen.sv
// conv_addr_gen: sliding-window input address generator streaming one tensor address per handshake
module conv_addr_gen #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  in_h,
  input  logic [DIM_W-1:0]  in_w,
  input  logic [DIM_W-1:0]  in_ch,
  input  logic [DIM_W-1:0]  kernel_h,
  input  logic [DIM_W-1:0]  kernel_w,
  input  logic [DIM_W-1:0]  stride_h,
  input  logic [DIM_W-1:0]  stride_w,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              win_last,
  output logic              last,
  output logic              idle,
  output logic              done,
  output logic              cfg_err
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_GEN, S_DONE} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] base_r, row_step, col_step, wrow_step;
  logic [ADDR_W-1:0] win_row, win_base, row_ptr, win_row_n, win_base_n, row_ptr_n, addr_n;
  logic [DIM_W-1:0] in_h_r, in_w_r, in_ch_r, kh_r, kw_r, sh_r, sw_r;
  logic [DIM_W-1:0] ch_m, kw_m, kh_m, oh_m, ow_m, oh_m_n, ow_m_n, oh_calc, ow_calc, sh_d, sw_d;
  logic [DIM_W-1:0] c, kx, ky, ox, oy, c_n, kx_n, ky_n, ox_n, oy_n;
  logic err, err_n, bad, hs, win_last_n, last_n;
  assign ch_m = in_ch_r - 1'b1;
  assign kw_m = kw_r - 1'b1;
  assign kh_m = kh_r - 1'b1;
  assign sh_d = (sh_r == '0) ? DIM_W'(1) : sh_r;
  assign sw_d = (sw_r == '0) ? DIM_W'(1) : sw_r;
  assign oh_calc = (in_h_r - kh_r) / sh_d;
  assign ow_calc = (in_w_r - kw_r) / sw_d;
  assign bad = (in_ch_r == '0) || (kh_r == '0) || (kw_r == '0) || (sh_r == '0) ||
               (sw_r == '0) || (kh_r > in_h_r) || (kw_r > in_w_r);
  assign hs = (state == S_GEN) && addr_ready;
  assign addr_valid = (state == S_GEN);
  assign idle = (state == S_IDLE);
  assign done = (state == S_DONE);
  assign cfg_err = (state == S_DONE) && err;
  // Within one kernel row the kx/c elements are contiguous, so addr just increments;
  // row, window and window-row transitions jump by precomputed strides.
  always_comb begin
    state_n = state;
    err_n = err;
    oh_m_n = oh_m;
    ow_m_n = ow_m;
    c_n = c;
    kx_n = kx;
    ky_n = ky;
    ox_n = ox;
    oy_n = oy;
    win_row_n = win_row;
    win_base_n = win_base;
    row_ptr_n = row_ptr;
    addr_n = addr;
    if (state == S_IDLE && start) state_n = S_SETUP;
    if (state == S_DONE) state_n = S_IDLE;
    if (state == S_SETUP) begin
      state_n = bad ? S_DONE : S_GEN;
      err_n = bad;
      oh_m_n = oh_calc;
      ow_m_n = ow_calc;
      c_n = '0;
      kx_n = '0;
      ky_n = '0;
      ox_n = '0;
      oy_n = '0;
      win_row_n = base_r;
      win_base_n = base_r;
      row_ptr_n = base_r;
      addr_n = base_r;
    end
    if (hs) begin
      if (last) state_n = S_DONE;
      if (c != ch_m) begin
        c_n = c + 1'b1;
        addr_n = addr + 1'b1;
      end else if (kx != kw_m) begin
        c_n = '0;
        kx_n = kx + 1'b1;
        addr_n = addr + 1'b1;
      end else if (ky != kh_m) begin
        c_n = '0;
        kx_n = '0;
        ky_n = ky + 1'b1;
        row_ptr_n = row_ptr + row_step;
        addr_n = row_ptr + row_step;
      end else if (ox != ow_m) begin
        c_n = '0;
        kx_n = '0;
        ky_n = '0;
        ox_n = ox + 1'b1;
        win_base_n = win_base + col_step;
        row_ptr_n = win_base + col_step;
        addr_n = win_base + col_step;
      end else begin
        c_n = '0;
        kx_n = '0;
        ky_n = '0;
        ox_n = '0;
        oy_n = oy + 1'b1;
        win_row_n = win_row + wrow_step;
        win_base_n = win_row + wrow_step;
        row_ptr_n = win_row + wrow_step;
        addr_n = win_row + wrow_step;
      end
    end
    win_last_n = (state_n == S_GEN) && (c_n == ch_m) && (kx_n == kw_m) && (ky_n == kh_m);
    last_n = win_last_n && (ox_n == ow_m_n) && (oy_n == oh_m_n);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      addr <= '0;
      win_last <= 1'b0;
      last <= 1'b0;
      err <= 1'b0;
      c <= '0;
      kx <= '0;
      ky <= '0;
      ox <= '0;
      oy <= '0;
      oh_m <= '0;
      ow_m <= '0;
      win_row <= '0;
      win_base <= '0;
      row_ptr <= '0;
      base_r <= '0;
      in_h_r <= '0;
      in_w_r <= '0;
      in_ch_r <= '0;
      kh_r <= '0;
      kw_r <= '0;
      sh_r <= '0;
      sw_r <= '0;
      row_step <= '0;
      col_step <= '0;
      wrow_step <= '0;
    end else begin
      state <= state_n;
      addr <= addr_n;
      win_last <= win_last_n;
      last <= last_n;
      err <= err_n;
      c <= c_n;
      kx <= kx_n;
      ky <= ky_n;
      ox <= ox_n;
      oy <= oy_n;
      oh_m <= oh_m_n;
      ow_m <= ow_m_n;
      win_row <= win_row_n;
      win_base <= win_base_n;
      row_ptr <= row_ptr_n;
      if (state == S_IDLE && start) begin
        base_r <= base_addr;
        in_h_r <= in_h;
        in_w_r <= in_w;
        in_ch_r <= in_ch;
        kh_r <= kernel_h;
        kw_r <= kernel_w;
        sh_r <= stride_h;
        sw_r <= stride_w;
      end
      if (state == S_SETUP) begin
        row_step <= ADDR_W'(in_w_r) * ADDR_W'(in_ch_r);
        col_step <= ADDR_W'(sw_r) * ADDR_W'(in_ch_r);
        wrow_step <= ADDR_W'(sh_r) * ADDR_W'(in_w_r) * ADDR_W'(in_ch_r);
      end
    end
  end
endmodule

// File: tb/tb_conv_addr_gen.sv
// tb_conv_addr_gen: directed self-checking bench for conv_addr_gen
module tb_conv_addr_gen;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, addr_ready = 1'b0;
  logic [15:0] base_addr = '0, in_h = '0, in_w = '0, in_ch = '0;
  logic [15:0] kernel_h = '0, kernel_w = '0, stride_h = '0, stride_w = '0;
  logic [15:0] addr;
  logic addr_valid, win_last, last, idle, done, cfg_err;
  int vecs = 0, errs = 0;
  logic [15:0] got_q[$];
  always #5 clk = ~clk;
  conv_addr_gen #(.ADDR_W(16), .DIM_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .in_h(in_h), .in_w(in_w), .in_ch(in_ch), .kernel_h(kernel_h), .kernel_w(kernel_w),
    .stride_h(stride_h), .stride_w(stride_w), .addr(addr), .addr_valid(addr_valid),
    .addr_ready(addr_ready), .win_last(win_last), .last(last), .idle(idle),
    .done(done), .cfg_err(cfg_err)
  );
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int b, ih, iw, ic, kh, kw, sh, sw);
    base_addr = 16'(b);
    in_h = 16'(ih);
    in_w = 16'(iw);
    in_ch = 16'(ic);
    kernel_h = 16'(kh);
    kernel_w = 16'(kw);
    stride_h = 16'(sh);
    stride_w = 16'(sw);
  endtask
  task automatic run_layer(input string tag, input int b, ih, iw, ic, kh, kw, sh, sw,
                           input int pct, input bit poke);
    logic [15:0] ea[$];
    bit ewl[$], el[$];
    int oh, ow, idx, cyc, first, budget;
    bit pv, pr, fin;
    logic [15:0] pa;
    logic pwl, pl;
    oh = (ih - kh) / sh + 1;
    ow = (iw - kw) / sw + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int ky = 0; ky < kh; ky++)
          for (int kx = 0; kx < kw; kx++)
            for (int c = 0; c < ic; c++) begin
              ea.push_back(16'(b + ((oy * sh + ky) * iw + ox * sw + kx) * ic + c));
              ewl.push_back(ky == kh - 1 && kx == kw - 1 && c == ic - 1);
              el.push_back(ky == kh - 1 && kx == kw - 1 && c == ic - 1 && oy == oh - 1 && ox == ow - 1);
            end
    got_q.delete();
    idx = 0;
    cyc = 0;
    first = -1;
    pv = 0;
    pr = 0;
    fin = 0;
    pa = '0;
    pwl = 0;
    pl = 0;
    budget = 4 * ea.size() + 40;
    drive(b, ih, iw, ic, kh, kw, sh, sw);
    start = 1'b1;
    while (!fin && cyc < budget) begin
      step();
      cyc++;
      start = poke && cyc == 6;
      if (cyc == 1 || (poke && cyc == 6)) drive(16'h0f0f, 3, 2, 7, 1, 1, 3, 3);
      if (pv && !pr && addr_valid) begin
        chk({tag, " stall addr"}, 32'(addr), 32'(pa));
        chk({tag, " stall win_last"}, 32'(win_last), 32'(pwl));
        chk({tag, " stall last"}, 32'(last), 32'(pl));
      end
      if (pv && !pr) chk({tag, " valid dropped"}, 32'(addr_valid), 32'd1);
      if (addr_valid) begin
        if (first < 0) first = cyc;
        if (idx < ea.size()) begin
          chk($sformatf("%s addr[%0d]", tag, idx), 32'(addr), 32'(ea[idx]));
          chk($sformatf("%s win_last[%0d]", tag, idx), 32'(win_last), 32'(ewl[idx]));
          chk($sformatf("%s last[%0d]", tag, idx), 32'(last), 32'(el[idx]));
        end else chk({tag, " overrun"}, 32'(idx), 32'(ea.size()));
      end
      if (done) begin
        chk({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
        chk({tag, " handshakes"}, 32'(idx), 32'(ea.size()));
        if (pct == 100) chk({tag, " done cycle"}, 32'(cyc), 32'(ea.size() + 2));
        fin = 1;
      end
      pv = addr_valid;
      pa = addr;
      pwl = win_last;
      pl = last;
      addr_ready = ($urandom_range(99) < pct);
      pr = addr_ready;
      if (addr_valid && addr_ready) begin
        got_q.push_back(addr);
        idx++;
      end
    end
    chk({tag, " done seen"}, 32'(fin), 32'd1);
    chk({tag, " first valid cycle"}, 32'(first), 32'd2);
    addr_ready = 1'b0;
    step();
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " idle after"}, 32'(idle), 32'd1);
  endtask
  task automatic run_bad(input string tag, input int ih, kh, sw);
    drive(0, ih, 4, 1, kh, 4, 1, sw);
    start = 1'b1;
    addr_ready = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " c1 valid"}, 32'(addr_valid), 32'd0);
    chk({tag, " c1 done"}, 32'(done), 32'd0);
    chk({tag, " c1 idle"}, 32'(idle), 32'd0);
    step();
    chk({tag, " c2 done"}, 32'(done), 32'd1);
    chk({tag, " c2 cfg_err"}, 32'(cfg_err), 32'd1);
    chk({tag, " c2 valid"}, 32'(addr_valid), 32'd0);
    step();
    chk({tag, " c3 idle"}, 32'(idle), 32'd1);
    chk({tag, " c3 done"}, 32'(done), 32'd0);
    chk({tag, " c3 cfg_err"}, 32'(cfg_err), 32'd0);
    chk({tag, " c3 valid"}, 32'(addr_valid), 32'd0);
    addr_ready = 1'b0;
  endtask
  initial begin
    step();
    step();
    chk("rst addr", 32'(addr), 32'd0);
    chk("rst valid", 32'(addr_valid), 32'd0);
    chk("rst win_last", 32'(win_last), 32'd0);
    chk("rst last", 32'(last), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst cfg_err", 32'(cfg_err), 32'd0);
    chk("rst idle", 32'(idle), 32'd1);
    reset_n = 1'b1;
    step();
    run_layer("t1", 0, 4, 4, 1, 4, 4, 1, 1, 100, 0);
    chk("t1 first", 32'(got_q[0]), 32'h0);
    chk("t1 final", 32'(got_q[15]), 32'hf);
    run_layer("t2", 'h100, 5, 5, 2, 4, 4, 1, 1, 100, 0);
    chk("t2 count", 32'(got_q.size()), 32'd128);
    chk("t2 win01", 32'(got_q[32]), 32'h102);
    chk("t2 win10", 32'(got_q[64]), 32'h10a);
    chk("t2 final", 32'(got_q[127]), 32'h131);
    run_layer("t3", 0, 8, 8, 1, 4, 4, 2, 2, 100, 0);
    chk("t3 count", 32'(got_q.size()), 32'd144);
    chk("t3 win01", 32'(got_q[16]), 32'h2);
    chk("t3 win10", 32'(got_q[48]), 32'h10);
    run_layer("t4", 'h100, 5, 5, 2, 4, 4, 1, 1, 50, 0);
    chk("t4 count", 32'(got_q.size()), 32'd128);
    chk("t4 final", 32'(got_q[127]), 32'h131);
    run_bad("t5 kh", 4, 5, 1);
    run_bad("t5 sw", 4, 4, 0);
    run_layer("t6 poke", 'h100, 5, 5, 2, 4, 4, 1, 1, 100, 1);
    chk("t6 poke final", 32'(got_q[127]), 32'h131);
    drive('h100, 5, 5, 2, 4, 4, 1, 1);
    start = 1'b1;
    addr_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("t6 midlayer valid", 32'(addr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6 rst valid", 32'(addr_valid), 32'd0);
    chk("t6 rst idle", 32'(idle), 32'd1);
    chk("t6 rst done", 32'(done), 32'd0);
    addr_ready = 1'b0;
    repeat (3) begin
      step();
      chk("t6 rst no done", 32'(done), 32'd0);
    end
    reset_n = 1'b1;
    step();
    run_layer("t6 restart", 'h40, 4, 4, 1, 4, 4, 1, 1, 100, 0);
    chk("t6 restart first", 32'(got_q[0]), 32'h40);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
